eth_clkout_gen: RTL and testbench
=================================

ETH_CLKOUT_GEN -- requirements
Module: eth_clkout_gen

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of half-period and pulse-count registers.
REQ-002 SHALL have parameter RST_HALF, default 4: reset value of HALF register.
REQ-003 SHALL have one clock and an asynchronous active-high reset: port clk, input, 1, rising-edge clock for all state.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port address, input, 3, Avalon-MM slave word address.
REQ-006 SHALL have port chipselect, input, 1, slave select.
REQ-007 SHALL have port write_n, input, 1, active-low write strobe.
REQ-008 SHALL have port writedata, input, 32, write data.
REQ-009 SHALL have port readdata, output, 32, registered read data.
REQ-010 SHALL have port out_port, output, 1, generated clock/pulse pin, driven from a flop.
REQ-011 SHALL have port irq, output, 1, done interrupt.

Function
REQ-012 SHALL decode the register map as follows: 0 LEVEL (bit0 idle level, R/W); 1 HALF (CNT_W bits, R/W); 2 COUNT (CNT_W bits, R/W); 3 CONTROL (write: bit0 start, bit1 stop; read: bit0 busy); 4 STATUS (bit0 done, sticky; any write clears it); 5 IRQMASK (bit0, R/W).
REQ-013 SHALL register write when chipselect=1 and write_n=0, and apply it on that clk edge.
REQ-014 SHALL update readdata every cycle from the address-selected register, giving 1-cycle read latency; unused bits and unmapped addresses read 0.
REQ-015 SHALL implement FSM IDLE, HIGH, LOW.
REQ-016 IDLE: out_port = LEVEL bit0; start moves to HIGH, loads phase counter with HALF and pulse counter with 0, and sets out_port=1 on the next edge.
REQ-017 HIGH: out_port=1 for exactly max(HALF,1) cycles, then LOW.
REQ-018 LOW: out_port=0 for exactly max(HALF,1) cycles, then increment the pulse counter.
REQ-019 After LOW, if COUNT≠0 and the pulse count equals COUNT, SHALL go to IDLE and set done; otherwise SHALL go to HIGH.
REQ-020 COUNT=0 SHALL mean continuous operation: done never sets and the pulse counter wraps modulo 2^CNT_W.
REQ-021 SHALL sample HALF and COUNT at start and at each phase reload, so writes during a run take effect at the next phase.
REQ-022 Stop in HIGH or LOW SHALL go to IDLE on the same edge, drive out_port=LEVEL bit0, and leave done unset.
REQ-023 Start while busy SHALL be ignored.
REQ-024 If start and stop are written together, stop SHALL win.
REQ-025 If a STATUS write and done-set occur in the same cycle, set SHALL win.
REQ-026 busy SHALL be 1 in HIGH or LOW, and 0 in IDLE.
REQ-027 irq SHALL equal done & IRQMASK bit0, registered.

Reset
REQ-028 Reset SHALL take effect immediately and asynchronously, independent of clk.
REQ-029 Reset values SHALL be: FSM=IDLE; LEVEL=0; HALF=RST_HALF; COUNT=0; IRQMASK=0; done=0; counters=0; readdata=0; out_port=0; irq=0.
REQ-030 Reset during a run SHALL abort the run with no done.

Structure
REQ-031 SHALL place the FSM state encoding, register address constants and CONTROL/STATUS bit indices in shared package eth_clkout_pkg.
REQ-032 SHALL have one natural sub-module: eth_clkout_timer, holding the phase down-counter and pulse counter with load/decrement/terminal-count outputs. The register file and FSM stay in the top.

Verification
REQ-033 Reset, then read all addresses -> readdata returns 0, except HALF=RST_HALF; out_port=0.
REQ-034 HALF=3, COUNT=2, start -> out_port shows 3 high, 3 low, 3 high, 3 low, then idle at LEVEL; busy=1 throughout; done=1 after the final low phase.
REQ-035 HALF=0, COUNT=0, start -> out_port toggles every cycle indefinitely with done=0; stop mid-HIGH -> out_port=LEVEL on the next cycle and busy=0.
REQ-036 IRQMASK=1, run COUNT=1 to done -> irq=1; write STATUS in the same cycle a second run completes -> done remains 1.
REQ-037 Start with start+stop together -> FSM stays IDLE; start while busy -> phase timing is unchanged.
REQ-038 Assert reset mid-LOW -> out_port=0, busy=0 and done=0 immediately, without a clk edge.

Source files
------------

// File: rtl/eth_clkout_pkg.sv
// Shared definitions for the Avalon-MM programmable clock/pulse generator:
// FSM encoding, register word addresses and CONTROL/STATUS bit positions.
package eth_clkout_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_e;

  localparam logic [2:0] ADDR_LEVEL   = 3'd0;
  localparam logic [2:0] ADDR_HALF    = 3'd1;
  localparam logic [2:0] ADDR_COUNT   = 3'd2;
  localparam logic [2:0] ADDR_CONTROL = 3'd3;
  localparam logic [2:0] ADDR_STATUS  = 3'd4;
  localparam logic [2:0] ADDR_IRQMASK = 3'd5;

  localparam int CTRL_START_BIT = 0;
  localparam int CTRL_STOP_BIT  = 1;
  localparam int CTRL_BUSY_BIT  = 0;
  localparam int STAT_DONE_BIT  = 0;

endpackage

// File: rtl/eth_clkout_timer.sv
// Phase down-counter (terminal count at 1) and free-running pulse counter
// for the clock generator; the controlling FSM lives in the top.
module eth_clkout_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] load_val,
  input  logic             pulse_clr,
  input  logic             pulse_inc,
  output logic             phase_tc,
  output logic [CNT_W-1:0] pulse_cnt
);

  logic [CNT_W-1:0] phase_d, phase_q;
  logic [CNT_W-1:0] pulse_d, pulse_q;

  always_comb begin
    phase_d = phase_q;
    pulse_d = pulse_q;
    if (load) begin
      phase_d = load_val;
    end else if (dec && (phase_q != {CNT_W{1'b0}})) begin
      phase_d = phase_q - {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      phase_d = phase_q;
    end
    if (pulse_clr) begin
      pulse_d = {CNT_W{1'b0}};
    end else if (pulse_inc) begin
      pulse_d = pulse_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      pulse_d = pulse_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q <= {CNT_W{1'b0}};
      pulse_q <= {CNT_W{1'b0}};
    end else begin
      phase_q <= phase_d;
      pulse_q <= pulse_d;
    end
  end

  // Phase is loaded with max(HALF,1), so a value of 1 marks the last cycle.
  assign phase_tc  = (phase_q <= {{(CNT_W-1){1'b0}}, 1'b1});
  assign pulse_cnt = pulse_q;

endmodule

// File: rtl/eth_clkout_gen.sv
// Avalon-MM programmable clock/pulse generator: register file, IDLE/HIGH/LOW
// FSM driving out_port from a flop, sticky done flag and masked interrupt.
module eth_clkout_gen
  import eth_clkout_pkg::*;
#(
  parameter int CNT_W    = 16,
  parameter int RST_HALF = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        out_port,
  output logic        irq
);

  state_e           state_d, state_q;
  logic             out_d, out_q;
  logic             level_d, level_q;
  logic [CNT_W-1:0] half_d, half_q;
  logic [CNT_W-1:0] count_d, count_q;
  logic             irqmask_d, irqmask_q;
  logic             done_d, done_q;
  logic             irq_d, irq_q;
  logic [31:0]      readdata_d, readdata_q;

  logic             wr, start_req, stop_req, done_set;
  logic             t_load, t_dec, t_pclr, t_pinc, phase_tc;
  logic [CNT_W-1:0] half_eff, pulse_cnt, pulse_next;
  logic             unused_wdata;

  assign unused_wdata = ^writedata;

  eth_clkout_timer #(.CNT_W(CNT_W)) u_timer (
    .clk       (clk),
    .reset     (reset),
    .load      (t_load),
    .dec       (t_dec),
    .load_val  (half_eff),
    .pulse_clr (t_pclr),
    .pulse_inc (t_pinc),
    .phase_tc  (phase_tc),
    .pulse_cnt (pulse_cnt)
  );

  always_comb begin
    wr         = chipselect & ~write_n;
    start_req  = wr && (address == ADDR_CONTROL) && writedata[CTRL_START_BIT];
    stop_req   = wr && (address == ADDR_CONTROL) && writedata[CTRL_STOP_BIT];
    half_eff   = (half_q == {CNT_W{1'b0}}) ? {{(CNT_W-1){1'b0}}, 1'b1} : half_q;
    pulse_next = pulse_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    state_d    = state_q;
    out_d      = out_q;
    done_set   = 1'b0;
    t_load     = 1'b0;
    t_dec      = 1'b0;
    t_pclr     = 1'b0;
    t_pinc     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Stop in the same write suppresses start.
        if (start_req && !stop_req) begin
          state_d = ST_HIGH;
          out_d   = 1'b1;
          t_load  = 1'b1;
          t_pclr  = 1'b1;
        end else begin
          state_d = ST_IDLE;
          out_d   = level_q;
        end
      end
      ST_HIGH: begin
        if (stop_req) begin
          state_d = ST_IDLE;
          out_d   = level_q;
        end else if (phase_tc) begin
          state_d = ST_LOW;
          out_d   = 1'b0;
          t_load  = 1'b1;
        end else begin
          out_d = 1'b1;
          t_dec = 1'b1;
        end
      end
      ST_LOW: begin
        if (stop_req) begin
          state_d = ST_IDLE;
          out_d   = level_q;
        end else if (phase_tc) begin
          t_pinc = 1'b1;
          if ((count_q != {CNT_W{1'b0}}) && (pulse_next == count_q)) begin
            state_d  = ST_IDLE;
            out_d    = level_q;
            done_set = 1'b1;
          end else begin
            state_d = ST_HIGH;
            out_d   = 1'b1;
            t_load  = 1'b1;
          end
        end else begin
          out_d = 1'b0;
          t_dec = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        out_d   = level_q;
      end
    endcase
  end

  always_comb begin
    level_d   = (wr && (address == ADDR_LEVEL))   ? writedata[0]         : level_q;
    half_d    = (wr && (address == ADDR_HALF))    ? writedata[CNT_W-1:0] : half_q;
    count_d   = (wr && (address == ADDR_COUNT))   ? writedata[CNT_W-1:0] : count_q;
    irqmask_d = (wr && (address == ADDR_IRQMASK)) ? writedata[0]         : irqmask_q;
    // A completing run outranks a simultaneous STATUS clear.
    if (done_set) begin
      done_d = 1'b1;
    end else if (wr && (address == ADDR_STATUS)) begin
      done_d = 1'b0;
    end else begin
      done_d = done_q;
    end
    irq_d      = done_q & irqmask_q;
    readdata_d = 32'd0;
    case (address)
      ADDR_LEVEL:   readdata_d[0]              = level_q;
      ADDR_HALF:    readdata_d[CNT_W-1:0]      = half_q;
      ADDR_COUNT:   readdata_d[CNT_W-1:0]      = count_q;
      ADDR_CONTROL: readdata_d[CTRL_BUSY_BIT]  = (state_q != ST_IDLE);
      ADDR_STATUS:  readdata_d[STAT_DONE_BIT]  = done_q;
      ADDR_IRQMASK: readdata_d[0]              = irqmask_q;
      default:      readdata_d                 = 32'd0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      out_q      <= 1'b0;
      level_q    <= 1'b0;
      half_q     <= CNT_W'(RST_HALF);
      count_q    <= {CNT_W{1'b0}};
      irqmask_q  <= 1'b0;
      done_q     <= 1'b0;
      irq_q      <= 1'b0;
      readdata_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      out_q      <= out_d;
      level_q    <= level_d;
      half_q     <= half_d;
      count_q    <= count_d;
      irqmask_q  <= irqmask_d;
      done_q     <= done_d;
      irq_q      <= irq_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  assign out_port = out_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_eth_clkout_gen.sv
// Directed, table-driven bench for eth_clkout_gen: register map, pulse
// timing, continuous mode, stop/start corner cases, irq and async reset.
module tb_eth_clkout_gen;
  import eth_clkout_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [2:0]  address = 3'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'd0;
  logic [31:0] readdata;
  logic        out_port;
  logic        irq;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t        vecs[9];
  logic [31:0] rdat;
  logic [12:0] pat;

  eth_clkout_gen #(.CNT_W(16), .RST_HALF(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Called at a negedge; the write lands on the following posedge.
  task automatic wr_reg(input logic [2:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd_reg(input logic [2:0] a, output logic [31:0] d);
    address = a;
    @(negedge clk);
    d = readdata;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{ADDR_LEVEL,   32'hFFFF_FFFF, 32'h0000_0001};
    vecs[1] = '{ADDR_HALF,    32'h1234_5678, 32'h0000_5678};
    vecs[2] = '{ADDR_COUNT,   32'hABCD_0002, 32'h0000_0002};
    vecs[3] = '{ADDR_IRQMASK, 32'h0000_0003, 32'h0000_0001};
    vecs[4] = '{3'd6,         32'hFFFF_FFFF, 32'h0000_0000};
    vecs[5] = '{3'd7,         32'hFFFF_FFFF, 32'h0000_0000};
    vecs[6] = '{ADDR_CONTROL, 32'h0000_0000, 32'h0000_0000};
    vecs[7] = '{ADDR_LEVEL,   32'h0000_0000, 32'h0000_0000};
    vecs[8] = '{ADDR_IRQMASK, 32'h0000_0000, 32'h0000_0000};

    // Reset state
    #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_out", {31'd0, out_port}, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    reset = 1'b0;
    for (int a = 0; a < 8; a++) begin
      rd_reg(3'(a), rdat);
      check($sformatf("rst_read_a%0d", a), rdat, (a == 1) ? 32'd4 : 32'd0);
    end

    for (int i = 0; i < 9; i++) begin
      wr_reg(vecs[i].addr, vecs[i].wdata);
      rd_reg(vecs[i].addr, rdat);
      check($sformatf("regvec_%0d", i), rdat, vecs[i].exp);
    end

    // HALF=3, COUNT=2 with idle level 1
    wr_reg(ADDR_LEVEL, 32'd1);
    wr_reg(ADDR_HALF, 32'd3);
    wr_reg(ADDR_COUNT, 32'd2);
    wr_reg(ADDR_CONTROL, 32'd1);
    pat = 13'b1000111000111;
    for (int k = 0; k < 13; k++) begin
      check($sformatf("burst_out_%0d", k), {31'd0, out_port}, {31'd0, pat[k]});
      if (k >= 1) check($sformatf("burst_busy_%0d", k), readdata, 32'd1);
      @(negedge clk);
    end
    check("burst_busy_end", readdata, 32'd0);
    rd_reg(ADDR_STATUS, rdat);
    check("burst_done", rdat, 32'd1);
    check("burst_irq_masked", {31'd0, irq}, 32'd0);
    wr_reg(ADDR_STATUS, 32'd0);
    rd_reg(ADDR_STATUS, rdat);
    check("done_clear", rdat, 32'd0);

    // HALF=0, COUNT=0: toggle every cycle, then stop mid-HIGH
    wr_reg(ADDR_HALF, 32'd0);
    wr_reg(ADDR_COUNT, 32'd0);
    wr_reg(ADDR_CONTROL, 32'd1);
    for (int k = 0; k < 20; k++) begin
      check($sformatf("cont_out_%0d", k), {31'd0, out_port}, (k % 2 == 0) ? 32'd1 : 32'd0);
      @(negedge clk);
    end
    check("cont_pre_stop_high", {31'd0, out_port}, 32'd1);
    wr_reg(ADDR_CONTROL, 32'd2);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("stop_level_%0d", k), {31'd0, out_port}, 32'd1);
      @(negedge clk);
    end
    rd_reg(ADDR_CONTROL, rdat);
    check("stop_busy", rdat, 32'd0);
    rd_reg(ADDR_STATUS, rdat);
    check("cont_done", rdat, 32'd0);

    // irq, then STATUS clear colliding with a completion
    wr_reg(ADDR_LEVEL, 32'd0);
    wr_reg(ADDR_IRQMASK, 32'd1);
    wr_reg(ADDR_HALF, 32'd1);
    wr_reg(ADDR_COUNT, 32'd1);
    wr_reg(ADDR_CONTROL, 32'd1);
    @(negedge clk);
    @(negedge clk);
    check("irq_pre", {31'd0, irq}, 32'd0);
    @(negedge clk);
    check("irq_set", {31'd0, irq}, 32'd1);
    wr_reg(ADDR_STATUS, 32'd0);
    wr_reg(ADDR_CONTROL, 32'd1);
    check("irq_cleared", {31'd0, irq}, 32'd0);
    @(negedge clk);
    wr_reg(ADDR_STATUS, 32'd0);
    rd_reg(ADDR_STATUS, rdat);
    check("set_beats_clear", rdat, 32'd1);
    check("irq_second", {31'd0, irq}, 32'd1);

    // start+stop together, then start while busy
    wr_reg(ADDR_STATUS, 32'd0);
    wr_reg(ADDR_CONTROL, 32'd3);
    check("startstop_out", {31'd0, out_port}, 32'd0);
    rd_reg(ADDR_CONTROL, rdat);
    check("startstop_busy", rdat, 32'd0);
    wr_reg(ADDR_LEVEL, 32'd1);
    wr_reg(ADDR_HALF, 32'd2);
    wr_reg(ADDR_COUNT, 32'd1);
    wr_reg(ADDR_CONTROL, 32'd1);
    check("rstart_0", {31'd0, out_port}, 32'd1);
    wr_reg(ADDR_CONTROL, 32'd1);
    check("rstart_1", {31'd0, out_port}, 32'd1);
    @(negedge clk);
    check("rstart_2", {31'd0, out_port}, 32'd0);
    @(negedge clk);
    check("rstart_3", {31'd0, out_port}, 32'd0);
    @(negedge clk);
    check("rstart_4", {31'd0, out_port}, 32'd1);

    // Async reset mid-LOW with done and irq already set
    wr_reg(ADDR_LEVEL, 32'd0);
    wr_reg(ADDR_HALF, 32'd4);
    wr_reg(ADDR_COUNT, 32'd0);
    wr_reg(ADDR_CONTROL, 32'd1);
    repeat (5) @(negedge clk);
    check("midlow_out", {31'd0, out_port}, 32'd0);
    check("midlow_busy", readdata, 32'd1);
    check("midlow_irq", {31'd0, irq}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check("arst_out", {31'd0, out_port}, 32'd0);
    check("arst_readdata", readdata, 32'd0);
    check("arst_irq", {31'd0, irq}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    rd_reg(ADDR_CONTROL, rdat);
    check("post_rst_busy", rdat, 32'd0);
    rd_reg(ADDR_STATUS, rdat);
    check("post_rst_done", rdat, 32'd0);
    rd_reg(ADDR_HALF, rdat);
    check("post_rst_half", rdat, 32'd4);
    check("post_rst_out", {31'd0, out_port}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
